// File: rtl/led_display_queue_pkg.sv
// Shared definitions for the LED display queue: data width and FSM state encoding.
package led_display_queue_pkg;

    localparam int LED_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } ledState_t;

endpackage

// File: rtl/led_display_queue_sync_fifo.sv
// Small synchronous FIFO with a combinational head output and registered occupancy.
// The storage array is not reset; its contents are unreachable while the count is zero.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] dataIn,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   count;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            if (doPush && !doPop)      count <= count + 1'b1;
            else if (doPop && !doPush) count <= count - 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtr] <= dataIn;
    end

    assign head  = mem[rdPtr];
    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/led_display_queue.sv
// Queues CPU LED writes and holds each value on the board LEDs for HOLD_CYCLES clocks.
// state | meaning
// IDLE  | nothing being shown, oLed keeps the last value
// SHOW  | value held on oLed, hold counter running down to zero
module led_display_queue
    import led_display_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 iWriteEnable,
    input  logic [LED_WIDTH-1:0] iData,
    output logic [LED_WIDTH-1:0] oLed,
    output logic                 oEmpty,
    output logic                 oFull,
    output logic                 oBusy,
    output logic                 oDropped
);

    localparam logic [31:0] HOLD_RELOAD = 32'(HOLD_CYCLES - 1);

    ledState_t            state;
    logic [31:0]          holdCount;
    logic [LED_WIDTH-1:0] fifoHead;
    logic                 fifoPop;
    logic                 fifoPush;

    // The next value is taken when idle or when the current hold expires, so holds run back-to-back.
    assign fifoPop  = !oEmpty && ((state == IDLE) || (holdCount == '0));
    assign fifoPush = iWriteEnable && (!oFull || fifoPop);

    sync_fifo #(
        .WIDTH (LED_WIDTH),
        .DEPTH (DEPTH)
    ) ledFifo (
        .Clock  (Clock),
        .Reset  (Reset),
        .push   (fifoPush),
        .pop    (fifoPop),
        .dataIn (iData),
        .head   (fifoHead),
        .full   (oFull),
        .empty  (oEmpty)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            holdCount <= '0;
            oLed      <= '0;
            oDropped  <= 1'b0;
        end else begin
            oDropped <= iWriteEnable && !fifoPush;
            if (fifoPop) begin
                oLed      <= fifoHead;
                holdCount <= HOLD_RELOAD;
                state     <= SHOW;
            end else if (state == SHOW) begin
                if (holdCount == '0) state <= IDLE;
                else                 holdCount <= holdCount - 1'b1;
            end
        end
    end

    assign oBusy = (state == SHOW);

endmodule

// File: tb/tb_led_display_queue.sv
// Scoreboard bench for led_display_queue: a queue-level reference model predicts acceptance,
// drops and flags; a negedge monitor checks the displayed sequence and exact hold lengths.
module tb_led_display_queue;

    localparam int DEPTH = 4;
    localparam int HOLD  = 3;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iWriteEnable = 1'b0;
    logic [7:0] iData = 8'h00;
    logic [7:0] oLed;
    logic       oEmpty, oFull, oBusy, oDropped;

    int vectors = 0;
    int miscompares = 0;

    // reference model: queued values, display activity, expected display order
    int  mq[$];
    int  sb[$];
    bit  mShowing = 1'b0;
    int  mShownFor = 0;

    led_display_queue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iWriteEnable (iWriteEnable),
        .iData        (iData),
        .oLed         (oLed),
        .oEmpty       (oEmpty),
        .oFull        (oFull),
        .oBusy        (oBusy),
        .oDropped     (oDropped)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model across the edge, then check the flags.
    task automatic step(input bit rst, input bit we, input logic [7:0] d);
        bit pop, accept, drop;
        Reset = rst;
        iWriteEnable = we;
        iData = d;
        pop    = !rst && mq.size() > 0 && (!mShowing || mShownFor == HOLD);
        accept = !rst && we && (mq.size() < DEPTH || pop);
        drop   = !rst && we && !accept;
        @(posedge Clock);
        #1;
        if (rst) begin
            mq.delete();
            sb.delete();
            mShowing = 1'b0;
            mShownFor = 0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                mShowing = 1'b1;
                mShownFor = 1;
            end else if (mShowing) begin
                if (mShownFor == HOLD) mShowing = 1'b0;
                else mShownFor++;
            end
            if (accept) begin
                mq.push_back(int'(d));
                sb.push_back(int'(d));
            end
        end
        check("oDropped", int'(oDropped), int'(drop));
        check("oEmpty", int'(oEmpty), int'(mq.size() == 0));
        check("oFull", int'(oFull), int'(mq.size() == DEPTH));
        check("oBusy", int'(oBusy), int'(mShowing));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: every new display must be the next expected value and last exactly HOLD clocks.
    initial begin : monitor
        int holdLeft;
        logic [7:0] lastVal;
        holdLeft = 0;
        lastVal = 8'h00;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                holdLeft = 0;
                lastVal = 8'h00;
            end else if (oBusy) begin
                if (holdLeft == 0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_display", int'(oLed), -1);
                    end else begin
                        check("display_value", int'(oLed), sb.pop_front());
                    end
                    lastVal = oLed;
                    holdLeft = HOLD - 1;
                end else begin
                    check("display_held", int'(oLed), int'(lastVal));
                    holdLeft--;
                end
            end else begin
                check("hold_length", holdLeft, 0);
                holdLeft = 0;
                check("idle_retains", int'(oLed), int'(lastVal));
            end
        end
    end

    initial begin : stimulus
        int guard;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'h99);
        check("reset_oLed", int'(oLed), 0);

        // single write and its one-edge latency
        step(1'b0, 1'b1, 8'hA5);
        check("latency_before", int'(oLed), 0);
        step(1'b0, 1'b0, 8'h00);
        check("latency_after", int'(oLed), 8'hA5);
        idle(6);
        check("single_retained", int'(oLed), 8'hA5);

        // burst of three
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 8'(i));
        idle(12);

        // overflow: back-to-back writes past capacity
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
        // keep writing while full so a write lands on the hold-expiry edge
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h30 + i));
        idle(40);

        // reset mid-SHOW with queued entries; write during reset ignored
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(8'h21 + i));
        step(1'b1, 1'b1, 8'h77);
        check("midshow_reset_oLed", int'(oLed), 0);
        check("midshow_reset_empty", int'(oEmpty), 1);
        idle(8);
        step(1'b0, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 8'h00);
        check("post_reset_write", int'(oLed), 8'h5A);
        idle(6);

        // pointer wrap: spaced writes
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 8'(8'h40 + i));
            idle(2);
        end
        idle(10);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) == 0), ($urandom_range(99) < 55), 8'($urandom_range(255)));
        end

        // drain and confirm every accepted value was shown
        guard = 0;
        while ((oBusy || !oEmpty) && guard < 200) begin
            step(1'b0, 1'b0, 8'h00);
            guard++;
        end
        check("drain_timeout", int'(guard < 200), 1);
        idle(2);
        check("scoreboard_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
